// File: rtl/key_event_pkg.sv
// Shared types for the key event controller: event codes, per-key FSM states
// and the 4-bit {key, code} event record carried through the event FIFO.
package key_event_pkg;

    localparam int NUM_KEYS = 3;
    localparam int KEY_W    = 2;
    localparam int CODE_W   = 2;
    localparam int EVT_W    = KEY_W + CODE_W;

    typedef enum logic [CODE_W-1:0] {
        EVT_PRESS   = 2'b00,
        EVT_LONG    = 2'b01,
        EVT_REPEAT  = 2'b10,
        EVT_RELEASE = 2'b11
    } evt_code_t;

    typedef enum logic [1:0] {
        ST_UP   = 2'd0,
        ST_DOWN = 2'd1,
        ST_RPT  = 2'd2
    } key_state_t;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        evt_code_t        code;
    } evt_t;

    // Key index 'offset' positions after 'base', wrapping over the key count.
    function automatic logic [KEY_W-1:0] rr_index(input logic [KEY_W-1:0] base,
                                                  input int offset);
        int sum;
        sum = int'(base) + offset;
        return KEY_W'(sum % NUM_KEYS);
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous show-ahead FIFO for key event records; the head entry is
// presented whenever valid is high and the occupancy is exported as level.
module key_event_fifo
    import key_event_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int WIDTH   = EVT_W,
    parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               ready,
    output logic               valid,
    output logic [WIDTH-1:0]   head,
    output logic               full,
    output logic               pop,
    output logic [LEVEL_W-1:0] level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [LEVEL_W-1:0] count;
    logic               do_push;

    assign valid   = (count != '0);
    assign full    = (count == LEVEL_W'(DEPTH));
    assign pop     = valid & ready;
    assign do_push = push & (~full | pop);
    assign head    = valid ? mem[rd_ptr] : '0;
    assign level   = count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order across always blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage carries no reset; head is masked to zero while empty, so
    // stale entries never reach the outputs.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Turns three debounced key levels into PRESS/LONG/REPEAT/RELEASE events,
// arbitrated round-robin into a show-ahead event FIFO for the CPU side.
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter  int TICK_DIV   = 48_000,
    parameter  int LONG_MS    = 1000,
    parameter  int REPEAT_MS  = 200,
    parameter  int FIFO_DEPTH = 4,
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          key_flag,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [1:0]          evt_key,
    output logic [1:0]          evt_code,
    output logic [LEVEL_W-1:0]  evt_level,
    output logic                overflow,
    input  logic                clr_overflow
);

    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int HCNT_W   = $clog2(HOLD_MAX + 1);

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [HCNT_W-1:0] LONG_LAST   = HCNT_W'(LONG_MS - 1);
    localparam logic [HCNT_W-1:0] REPEAT_LAST = HCNT_W'(REPEAT_MS - 1);

    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [NUM_KEYS-1:0] key_q;
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] fall;

    key_state_t          state     [NUM_KEYS];
    logic [HCNT_W-1:0]   hcnt      [NUM_KEYS];
    logic [NUM_KEYS-1:0] emit;
    evt_code_t           emit_code [NUM_KEYS];

    logic [NUM_KEYS-1:0] pend_valid;
    evt_code_t           pend_code [NUM_KEYS];
    logic [NUM_KEYS-1:0] accept;
    logic [NUM_KEYS-1:0] drop;

    logic [KEY_W-1:0]    rr_ptr;
    logic [KEY_W-1:0]    cand;
    logic [NUM_KEYS-1:0] grant;
    logic                grant_any;
    logic [KEY_W-1:0]    grant_key;
    evt_t                push_evt;
    evt_t                head_evt;
    logic                fifo_full;
    logic                fifo_pop;
    logic                can_push;

    // 1 ms time base
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_q <= '0;
        else     key_q <= key_flag;
    end

    assign rise = key_flag & ~key_q;
    assign fall = ~key_flag & key_q;

    // NOTE: every combinational output gets a default before the case logic,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            emit[k]      = 1'b0;
            emit_code[k] = EVT_PRESS;
            case (state[k])
                ST_UP: begin
                    if (rise[k]) emit[k] = 1'b1;
                end
                ST_DOWN: begin
                    if (fall[k]) begin
                        emit[k]      = 1'b1;
                        emit_code[k] = EVT_RELEASE;
                    end else if (tick && hcnt[k] == LONG_LAST) begin
                        emit[k]      = 1'b1;
                        emit_code[k] = EVT_LONG;
                    end
                end
                ST_RPT: begin
                    if (fall[k]) begin
                        emit[k]      = 1'b1;
                        emit_code[k] = EVT_RELEASE;
                    end else if (tick && hcnt[k] == REPEAT_LAST) begin
                        emit[k]      = 1'b1;
                        emit_code[k] = EVT_REPEAT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-key FSMs; a release always wins over a same-cycle LONG/REPEAT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state[k] <= ST_UP;
                hcnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                case (state[k])
                    ST_UP: begin
                        if (rise[k]) begin
                            hcnt[k]  <= '0;
                            state[k] <= ST_DOWN;
                        end
                    end
                    ST_DOWN: begin
                        if (fall[k]) begin
                            state[k] <= ST_UP;
                        end else if (tick) begin
                            if (hcnt[k] == LONG_LAST) begin
                                hcnt[k]  <= '0;
                                state[k] <= ST_RPT;
                            end else begin
                                hcnt[k] <= hcnt[k] + 1'b1;
                            end
                        end
                    end
                    ST_RPT: begin
                        if (fall[k]) begin
                            state[k] <= ST_UP;
                        end else if (tick) begin
                            if (hcnt[k] == REPEAT_LAST) hcnt[k] <= '0;
                            else                        hcnt[k] <= hcnt[k] + 1'b1;
                        end
                    end
                    default: state[k] <= ST_UP;
                endcase
            end
        end
    end

    // Round-robin grant, searching from the key after the last one granted.
    assign can_push = ~fifo_full | fifo_pop;

    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_key = '0;
        cand      = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cand = rr_index(rr_ptr, i);
            if (!grant_any && can_push && pend_valid[cand]) begin
                grant_any   = 1'b1;
                grant_key   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    assign push_evt.key  = grant_key;
    assign push_evt.code = pend_code[grant_key];

    // A slot being granted this cycle is free for a new event; a RELEASE may
    // replace a queued LONG/REPEAT, anything else hitting a busy slot is lost.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            accept[k] = emit[k] & (~(pend_valid[k] & ~grant[k]) |
                        ((emit_code[k] == EVT_RELEASE) &&
                         (pend_code[k] == EVT_LONG || pend_code[k] == EVT_REPEAT)));
            drop[k]   = emit[k] & ~accept[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= '0;
            for (int k = 0; k < NUM_KEYS; k++) pend_code[k] <= EVT_PRESS;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (accept[k]) begin
                    pend_valid[k] <= 1'b1;
                    pend_code[k]  <= emit_code[k];
                end else if (grant[k]) begin
                    pend_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            rr_ptr <= '0;
        else if (grant_any) rr_ptr <= rr_index(grant_key, 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               overflow <= 1'b0;
        else if (|drop)        overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

    key_event_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (EVT_W),
        .LEVEL_W (LEVEL_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_any),
        .push_data (push_evt),
        .ready     (evt_ready),
        .valid     (evt_valid),
        .head      (head_evt),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .level     (evt_level)
    );

    assign evt_key  = head_evt.key;
    assign evt_code = head_evt.code;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: directed scenarios plus random key
// traffic, all compared cycle by cycle against a timing-rule reference model.
module tb_key_event_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int LONG_MS    = 5;
    localparam int REPEAT_MS  = 2;
    localparam int FIFO_DEPTH = 4;

    localparam int C_PRESS   = 0;
    localparam int C_LONG    = 1;
    localparam int C_REPEAT  = 2;
    localparam int C_RELEASE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key_flag = 3'b000;
    logic       evt_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_key;
    logic [1:0] evt_code;
    logic [2:0] evt_level;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: hold time measured in whole ticks since the press.
    int       m_pend  [3];
    int       m_ticks [3];
    int       m_fifo  [$];
    int       m_rr;
    int       m_tcnt;
    bit [2:0] m_prev;
    bit       m_ovf;

    int dut_pops    [$];
    int dut_pop_cyc [$];

    key_event_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .LONG_MS    (LONG_MS),
        .REPEAT_MS  (REPEAT_MS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_flag     (key_flag),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_key      (evt_key),
        .evt_code     (evt_code),
        .evt_level    (evt_level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pend[k]  = -1;
            m_ticks[k] = 0;
        end
        m_fifo.delete();
        m_rr   = 0;
        m_tcnt = 0;
        m_prev = 3'b000;
        m_ovf  = 1'b0;
    endfunction

    function automatic void model_step(input logic [2:0] kf, input logic rdy, input logic clr);
        bit tick, pop, can_push, ovf_set;
        int g;
        int ev [3];
        tick     = (m_tcnt == TICK_DIV - 1);
        m_tcnt   = (m_tcnt + 1) % TICK_DIV;
        pop      = (m_fifo.size() > 0) && rdy;
        can_push = (m_fifo.size() < FIFO_DEPTH) || pop;
        g = -1;
        for (int i = 0; i < 3; i++) begin
            int idx;
            idx = (m_rr + i) % 3;
            if (g < 0 && can_push && m_pend[idx] >= 0) g = idx;
        end
        for (int k = 0; k < 3; k++) begin
            ev[k] = -1;
            if (kf[k] && !m_prev[k]) begin
                ev[k] = C_PRESS;
                m_ticks[k] = 0;
            end else if (!kf[k] && m_prev[k]) begin
                ev[k] = C_RELEASE;
            end else if (m_prev[k] && tick) begin
                m_ticks[k]++;
                if (m_ticks[k] == LONG_MS) ev[k] = C_LONG;
                else if (m_ticks[k] > LONG_MS && (m_ticks[k] - LONG_MS) % REPEAT_MS == 0)
                    ev[k] = C_REPEAT;
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (g >= 0) begin
            m_fifo.push_back(g * 4 + m_pend[g]);
            m_rr = (g + 1) % 3;
        end
        ovf_set = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bit busy;
            busy = (m_pend[k] >= 0) && (g != k);
            if (g == k) m_pend[k] = -1;
            if (ev[k] >= 0) begin
                if (!busy || (ev[k] == C_RELEASE && (m_pend[k] == C_LONG || m_pend[k] == C_REPEAT)))
                    m_pend[k] = ev[k];
                else
                    ovf_set = 1'b1;
            end
        end
        if (ovf_set)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_prev = kf;
    endfunction

    function automatic logic [8:0] exp_vec();
        if (m_fifo.size() == 0) return {8'b0, m_ovf};
        return {1'b1, 4'(m_fifo[0]), 3'(m_fifo.size()), m_ovf};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {evt_valid, evt_key, evt_code, evt_level, overflow};
    endfunction

    // Called at a falling edge: drives inputs, logs DUT pops, advances one clock.
    task automatic cycle(input logic [2:0] kf, input logic rdy, input logic clr);
        key_flag     = kf;
        evt_ready    = rdy;
        clr_overflow = clr;
        if (evt_valid && rdy) begin
            dut_pops.push_back(int'({evt_key, evt_code}));
            dut_pop_cyc.push_back(cyc);
        end
        model_step(kf, rdy, clr);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_pops();
        dut_pops.delete();
        dut_pop_cyc.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (dut_vec() !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b expected=%b", dut_vec(), 9'b0);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(3'b000, 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b expected=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] pat [8] = '{3'b111, 3'b000, 3'b010, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000};
        int batch1 [$];
        int cyc1   [$];
        clear_pops();
        for (int p = 0; p < 8; p++) begin
            if (p == 1) begin
                batch1 = dut_pops;
                cyc1   = dut_pop_cyc;
            end
            if (p == 4) clear_pops();
            for (int i = 0; i < 6; i++) begin
                cycle(pat[p], 1'b1, 1'b0);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL simultaneous cyc=%0d got=%b expected=%b", cyc, dut_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (batch1.size() != 3 || batch1[0] != 0 || batch1[1] != 4 || batch1[2] != 8 ||
            cyc1[1] != cyc1[0] + 1 || cyc1[2] != cyc1[1] + 1) begin
            errors++;
            $display("FAIL simultaneous_first_batch got=%p at %p expected=0,4,8 consecutive", batch1, cyc1);
        end
        checks++;
        if (dut_pops.size() < 3 || dut_pops[0] != 8 || dut_pops[1] != 0 || dut_pops[2] != 4) begin
            errors++;
            $display("FAIL simultaneous_rr_resume got=%p expected=8,0,4,...", dut_pops);
        end
    endtask

    task automatic test_single_press();
        clear_pops();
        for (int i = 0; i < 14; i++) begin
            cycle((i < 8) ? 3'b010 : 3'b000, 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_press cyc=%0d got=%b expected=%b", cyc, dut_vec(), exp_vec());
            end
            if (i == 0) begin
                checks++;
                if (evt_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL press_latency_1clk evt_valid=%b expected=0", evt_valid);
                end
            end
            if (i == 1) begin
                checks++;
                if ({evt_valid, evt_key, evt_code} !== 5'b1_01_00) begin
                    errors++;
                    $display("FAIL press_latency_2clk got=%b expected=10100", {evt_valid, evt_key, evt_code});
                end
            end
        end
        checks++;
        if (dut_pops.size() != 2 || dut_pops[0] != 4 || dut_pops[1] != 7 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL single_press_events got=%p ovf=%b expected=4,7 ovf=0", dut_pops, overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] pat [8] = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        clear_pops();
        for (int i = 0; i < 8; i++) begin
            cycle(pat[i], 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b expected=%b", cyc, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (dut_pops.size() != 4 || dut_pops[0] != 4 || dut_pops[1] != 7 ||
            dut_pops[2] != 4 || dut_pops[3] != 7) begin
            errors++;
            $display("FAIL back_to_back_events got=%p expected=4,7,4,7", dut_pops);
        end
    endtask

    task automatic test_long_hold();
        int n_rep;
        int idx;
        clear_pops();
        for (int i = 0; i < 46; i++) begin
            cycle((i < 40) ? 3'b001 : 3'b000, 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL long_hold cyc=%0d got=%b expected=%b", cyc, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (dut_pops.size() < 2 || dut_pops[0] != C_PRESS || dut_pops[1] != C_LONG ||
            dut_pop_cyc[1] - dut_pop_cyc[0] < 17 || dut_pop_cyc[1] - dut_pop_cyc[0] > 20) begin
            errors++;
            $display("FAIL long_timing got=%p at %p expected=0,1 with gap 17..20", dut_pops, dut_pop_cyc);
        end
        n_rep = 0;
        idx   = 2;
        while (idx < dut_pops.size() && dut_pops[idx] == C_REPEAT) begin
            checks++;
            if (dut_pop_cyc[idx] - dut_pop_cyc[idx-1] != 8) begin
                errors++;
                $display("FAIL repeat_period got=%0d expected=8", dut_pop_cyc[idx] - dut_pop_cyc[idx-1]);
            end
            n_rep++;
            idx++;
        end
        checks++;
        if (n_rep != 2 || idx != dut_pops.size() - 1 || dut_pops[idx] != C_RELEASE) begin
            errors++;
            $display("FAIL long_hold_events got=%p expected=0,1,2,2,3", dut_pops);
        end
    endtask

    task automatic test_overflow();
        clear_pops();
        for (int i = 0; i < 74; i++) begin
            cycle((i < 70) ? 3'b100 : 3'b000, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_fill cyc=%0d got=%b expected=%b", cyc, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (evt_level !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set level=%0d ovf=%b expected level=4 ovf=1", evt_level, overflow);
        end
        cycle(3'b000, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0 || evt_level !== 3'd4) begin
            errors++;
            $display("FAIL overflow_clear ovf=%b level=%0d expected ovf=0 level=4", overflow, evt_level);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(3'b000, 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_drain cyc=%0d got=%b expected=%b", cyc, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (dut_pops.size() != 5 || dut_pops[0] != 8 || dut_pops[1] != 9 || dut_pops[2] != 10 ||
            dut_pops[3] != 10 || dut_pops[4] != 11) begin
            errors++;
            $display("FAIL overflow_events got=%p expected=8,9,10,10,11", dut_pops);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 60 && evt_level != 3'd3; i++) begin
            cycle(3'b001, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL async_fill cyc=%0d got=%b expected=%b", cyc, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (evt_level !== 3'd3) begin
            errors++;
            $display("FAIL async_fill_bound level=%0d expected=3", evt_level);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 9'b0) begin
            errors++;
            $display("FAIL async_reset_outputs got=%b expected=%b", dut_vec(), 9'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_pops();
        for (int i = 0; i < 6; i++) begin
            cycle(3'b001, 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL async_restart cyc=%0d got=%b expected=%b", cyc, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (dut_pops.size() != 1 || dut_pops[0] != C_PRESS) begin
            errors++;
            $display("FAIL held_through_reset got=%p expected=0", dut_pops);
        end
        for (int i = 0; i < 4; i++) cycle(3'b000, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0] kf;
        logic       rdy;
        kf = 3'b000;
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 15) == 0) kf[k] = ~kf[k];
            rdy = (i < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cycle((i < 490) ? kf : 3'b000, (i < 490) ? rdy : 1'b1, ($urandom_range(0, 15) == 0));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b expected=%b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_simultaneous();
        test_single_press();
        test_back_to_back();
        test_long_hold();
        test_overflow();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
